ex_commit: RTL
==============

# ex_commit

Exception/ERET commit controller for the dual-issue pipeline's PMS stage, the producer side of the CP0 exception interface. Each cycle it takes the two-slot instruction bundle, arbitrates interrupt/exception/ERET events, and raises the single-instruction exception report into CP0. It then kills younger slots, flushes the pipeline and drives a PC redirect to the fetch unit through a valid/ready handshake.

## Interface
- EX_VECTOR, 32'hbfc00380: redirect target for every exception and interrupt (BEV=1 vector).
- FLUSH_CYCLES, 2: cycles `flush` stays high after the redirect handshake completes (1..15).
- clk  in  1  single clock, rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- inst1_valid / inst2_valid  in  1  slot valid; inst2_valid=1 implies inst1_valid=1.
- inst1_pc / inst2_pc  in  32  slot PC.
- inst1_ex / inst2_ex  in  1  slot carries a synchronous exception.
- inst1_excode / inst2_excode  in  5  Cause.ExcCode of that exception.
- inst1_badvaddr / inst2_badvaddr  in  32  faulting address.
- inst1_bd / inst2_bd  in  1  slot is a branch delay slot.
- inst1_eret / inst2_eret  in  1  slot is ERET.
- has_int  in  1  CP0 pending, enabled, unmasked interrupt.
- epc_res  in  32  CP0 EPC.
- pms_ex, pms_eret  out  1  one-cycle report to CP0.
- ex_type  out  5  ExcCode to CP0.
- pms_bd  out  1  BD of reporting slot.
- pms_pc, pms_badvaddr  out  32  PC / BadVAddr of reporting slot.
- inst1_commit / inst2_commit  out  1  slot may write GPR/CP0 (mtc0 gating).
- flush  out  1  kill all younger pipeline stages.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  32  redirect target.
- redirect_ready  in  1  fetch accepts redirect.
- ex_cnt, eret_cnt  out  32  event counters (see Configuration).

## Operation
- States: IDLE, REDIRECT, DRAIN.
- IDLE event priority:
  - has_int with inst1_valid: excode 0, slot-1 PC/BD.
  - slot-1 ex.
  - slot-1 eret.
  - slot-2 ex.
  - slot-2 eret.
  - has_int with inst1_valid=0 waits; no event.
- Reporting slot:
  - Drives pms_pc/pms_bd/pms_badvaddr.
  - ex_type = excode, or 0 for an interrupt.
  - pms_ex=1 for interrupt/exception; pms_eret=1 for ERET; never both.
- Commit gating:
  - Event on slot 1: both commits 0.
  - Event on slot 2: inst1_commit=inst1_valid, inst2_commit=0.
  - No event: commit=valid.
- Redirect target:
  - Exception/interrupt: EX_VECTOR.
  - ERET: epc_res sampled in the event cycle.
- IDLE --event--> REDIRECT. REDIRECT --redirect_ready--> DRAIN (FLUSH_CYCLES counter loaded). DRAIN --counter reaches 1--> IDLE.
- In REDIRECT and DRAIN:
  - All incoming bundles are wrong-path: commits 0, pms_ex/pms_eret 0, has_int ignored.
- Report outputs are 0 whenever pms_ex=pms_eret=0.

## Timing
- Reset values (all registered):
  - state=IDLE.
  - redirect_valid=0, redirect_pc=0, flush=0.
  - DRAIN counter=0.
  - ex_cnt=eret_cnt=0.
- pms_*, ex_type, commits:
  - Combinational from inputs and state, valid in the event cycle.
  - CP0 captures them on the same edge.
- flush:
  - Combinational in the event cycle.
  - Registered high through REDIRECT and all FLUSH_CYCLES DRAIN cycles.
- redirect_valid/redirect_pc:
  - Registered, rise at the edge after the event.
  - Held stable until the cycle redirect_ready=1.
  - redirect_valid drops on the next edge.
- redirect_ready while redirect_valid=0: ignored.
- Back-to-back events: earliest new report is the first IDLE cycle after DRAIN.
- resetn low mid-REDIRECT/DRAIN: immediate return to IDLE, all outputs at reset values, pending redirect dropped.

## Configuration
- EX_PERF_CNT_EN defined:
  - ex_cnt increments on each pms_ex cycle, eret_cnt on each pms_eret cycle.
  - Both wrap 32'hffffffff -> 0.
- EX_PERF_CNT_EN undefined: counters not built; ex_cnt=eret_cnt=0 constantly.

## Structure
- Shared package ex_pkg:
  - ExcCode constants: INT=5'h00, ADEL=5'h04, ADES=5'h05, SYS=5'h08, BP=5'h09, RI=5'h0a, OV=5'h0c.
  - State typedef.
  - Default EX_VECTOR.
- Sub-module ex_perf_cnt: two wrapping 32-bit counters, instantiated only under EX_PERF_CNT_EN.

## Test plan
- Slot-1 SYS, pc=0xbfc00100, bd=0 -> pms_ex=1, ex_type=5'h08, both commits 0, flush=1; next cycle redirect_valid=1, redirect_pc=0xbfc00380.
- Slot-2 OV, slot-2 bd=1, pc2=0xbfc00204 -> inst1_commit=1, inst2_commit=0, pms_bd=1, pms_pc=0xbfc00204.
- Slot-1 ERET, epc_res=0xbfc01000 -> pms_eret=1, pms_ex=0, redirect_pc=0xbfc01000.
- has_int=1 with slot-1 ADEL, badvaddr=0x3 -> interrupt wins: ex_type=0, both commits 0.
- redirect_ready low for 3 cycles -> redirect_valid/redirect_pc held; bundle with inst1_ex=1 arriving meanwhile is not reported; flush high 2 cycles after accept.
- resetn asserted in DRAIN -> state IDLE, flush=0, redirect_valid=0 immediately; with EX_PERF_CNT_EN, ex_cnt=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the PMS-stage exception/ERET commit controller:
// Cause.ExcCode values, controller state encoding and default redirect vector.
package ex_pkg;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;

   // BEV=1 general exception vector
   localparam logic [31:0] EX_VECTOR_DEF    = 32'hbfc00380;
   localparam int unsigned FLUSH_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_DRAIN    = 2'd2
   } ex_state_t;

endpackage : ex_pkg

// File: rtl/ex_perf_cnt.sv
// Exception / ERET event counters; both wrap from 32'hffffffff to 0.
// Only instantiated by ex_commit when EX_PERF_CNT_EN is defined.
module ex_perf_cnt (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inc_ex,
   input  logic        inc_eret,
   output logic [31:0] ex_cnt,
   output logic [31:0] eret_cnt
);

   logic [31:0] ex_cnt_q, ex_cnt_d;
   logic [31:0] eret_cnt_q, eret_cnt_d;

   // next count: natural 32-bit wrap on increment
   always_comb begin
      ex_cnt_d   = ex_cnt_q + {31'd0, inc_ex};
      eret_cnt_d = eret_cnt_q + {31'd0, inc_eret};
   end

   // counter registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ex_cnt_q   <= '0;
         eret_cnt_q <= '0;
      end else begin
         ex_cnt_q   <= ex_cnt_d;
         eret_cnt_q <= eret_cnt_d;
      end
   end

   assign ex_cnt   = ex_cnt_q;
   assign eret_cnt = eret_cnt_q;

endmodule : ex_perf_cnt

// File: rtl/ex_commit.sv
// Exception/ERET commit controller (PMS stage). Arbitrates interrupt,
// exception and ERET events across a two-slot bundle, reports one event to
// CP0, gates slot commits, flushes the pipe and issues a PC redirect.
// Optional event counters are built when EX_PERF_CNT_EN is defined.
module ex_commit
   import ex_pkg::*;
#(
   parameter logic [31:0] EX_VECTOR    = EX_VECTOR_DEF,
   parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst1_valid,
   input  logic        inst2_valid,
   input  logic [31:0] inst1_pc,
   input  logic [31:0] inst2_pc,
   input  logic        inst1_ex,
   input  logic        inst2_ex,
   input  logic [4:0]  inst1_excode,
   input  logic [4:0]  inst2_excode,
   input  logic [31:0] inst1_badvaddr,
   input  logic [31:0] inst2_badvaddr,
   input  logic        inst1_bd,
   input  logic        inst2_bd,
   input  logic        inst1_eret,
   input  logic        inst2_eret,
   input  logic        has_int,
   input  logic [31:0] epc_res,
   output logic        pms_ex,
   output logic        pms_eret,
   output logic [4:0]  ex_type,
   output logic        pms_bd,
   output logic [31:0] pms_pc,
   output logic [31:0] pms_badvaddr,
   output logic        inst1_commit,
   output logic        inst2_commit,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic [31:0] ex_cnt,
   output logic [31:0] eret_cnt
);

   ex_state_t   state_q, state_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        flush_q, flush_d;
   logic [3:0]  drain_cnt_q, drain_cnt_d;

   logic ev_ex, ev_eret, ev_slot2;

   // event arbitration: only IDLE accepts events; wrong-path bundles otherwise
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      ev_ex        = 1'b0;
      ev_eret      = 1'b0;
      ev_slot2     = 1'b0;
      ex_type      = 5'd0;
      pms_bd       = 1'b0;
      pms_pc       = '0;
      pms_badvaddr = '0;
      if (state_q == ST_IDLE && inst1_valid) begin
         if (has_int || inst1_ex || inst1_eret) begin
            ev_ex        = has_int || inst1_ex;
            ev_eret      = !(has_int || inst1_ex);
            ex_type      = has_int ? EXC_INT : (inst1_ex ? inst1_excode : 5'd0);
            pms_bd       = inst1_bd;
            pms_pc       = inst1_pc;
            pms_badvaddr = inst1_badvaddr;
         end else if (inst2_valid && (inst2_ex || inst2_eret)) begin
            ev_ex        = inst2_ex;
            ev_eret      = !inst2_ex;
            ev_slot2     = 1'b1;
            ex_type      = inst2_ex ? inst2_excode : 5'd0;
            pms_bd       = inst2_bd;
            pms_pc       = inst2_pc;
            pms_badvaddr = inst2_badvaddr;
         end
      end
   end

   assign pms_ex   = ev_ex;
   assign pms_eret = ev_eret;
   assign flush    = flush_q | ev_ex | ev_eret;

   // commit gating: an event kills its own slot and everything younger
   always_comb begin
      inst1_commit = 1'b0;
      inst2_commit = 1'b0;
      if (state_q == ST_IDLE) begin
         if (ev_slot2) begin
            inst1_commit = inst1_valid;
         end else if (!(ev_ex || ev_eret)) begin
            inst1_commit = inst1_valid;
            inst2_commit = inst2_valid;
         end
      end
   end

   // controller next state: redirect handshake then FLUSH_CYCLES of drain
   always_comb begin
      state_d          = state_q;
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      flush_d          = flush_q;
      drain_cnt_d      = drain_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (ev_ex || ev_eret) begin
               state_d          = ST_REDIRECT;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = ev_eret ? epc_res : EX_VECTOR;
               flush_d          = 1'b1;
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready) begin
               state_d          = ST_DRAIN;
               redirect_valid_d = 1'b0;
               drain_cnt_d      = FLUSH_CYCLES[3:0];
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q <= 4'd1) begin
               state_d     = ST_IDLE;
               flush_d     = 1'b0;
               drain_cnt_d = 4'd0;
            end else begin
               drain_cnt_d = drain_cnt_q - 4'd1;
            end
         end
         default: begin
            state_d          = ST_IDLE;
            redirect_valid_d = 1'b0;
            flush_d          = 1'b0;
            drain_cnt_d      = 4'd0;
         end
      endcase
   end

   // controller registers
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (!resetn) begin
         state_q          <= ST_IDLE;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         flush_q          <= 1'b0;
         drain_cnt_q      <= 4'd0;
      end else begin
         state_q          <= state_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         flush_q          <= flush_d;
         drain_cnt_q      <= drain_cnt_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

`ifdef EX_PERF_CNT_EN
   ex_perf_cnt u_perf_cnt (
      .clk      (clk),
      .resetn   (resetn),
      .inc_ex   (ev_ex),
      .inc_eret (ev_eret),
      .ex_cnt   (ex_cnt),
      .eret_cnt (eret_cnt)
   );
`else
   assign ex_cnt   = 32'd0;
   assign eret_cnt = 32'd0;
`endif

endmodule : ex_commit
